// File: rtl/exu_wb_arb.sv
// Write-back arbiter: lsu > alu > upr requests funnelled through an in-order FIFO onto one RF write port.
// Optional pending-write forwarding is enabled with `define EXU_WB_FWD_EN (ties fwd_hit/fwd_data low otherwise).
module exu_wb_arb #(
  parameter int DEPTH = 4
) (
  input  logic        hclk,
  input  logic        hrst,
  input  logic [4:0]  upr_waddr,
  input  logic        upr_wen,
  input  logic [31:0] upr_wdata,
  input  logic [4:0]  alu_waddr,
  input  logic        alu_wen,
  input  logic [31:0] alu_wdata,
  input  logic [4:0]  lsu_waddr,
  input  logic        lsu_wen,
  input  logic [31:0] lsu_wdata,
  output logic        exu_stall,
  output logic [4:0]  rf_waddr,
  output logic        rf_wen,
  output logic [31:0] rf_wdata,
  input  logic        rf_ready,
  input  logic [4:0]  fwd_raddr,
  output logic        fwd_hit,
  output logic [31:0] fwd_data
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [PW-1:0] r_rd_ptr;
  logic [PW-1:0] r_wr_ptr;
  logic [CW-1:0] r_count;
  logic [2:0]    r_served;
  logic [4:0]    r_mem_addr [DEPTH];
  logic [31:0]   r_mem_data [DEPTH];

  logic [2:0]  w_live;
  logic [1:0]  w_live_cnt;
  logic        w_full;
  logic        w_empty;
  logic        w_push;
  logic        w_pop;
  logic [2:0]  w_win_sel;
  logic [4:0]  w_win_addr;
  logic [31:0] w_win_data;

  // bit 2 = lsu, bit 1 = alu, bit 0 = upr; x0 writes never become live
  assign w_live[2] = lsu_wen & (lsu_waddr != 5'd0) & ~r_served[2];
  assign w_live[1] = alu_wen & (alu_waddr != 5'd0) & ~r_served[1];
  assign w_live[0] = upr_wen & (upr_waddr != 5'd0) & ~r_served[0];

  assign w_live_cnt = {1'b0, w_live[0]} + {1'b0, w_live[1]} + {1'b0, w_live[2]};
  assign w_full     = (r_count == CW'(DEPTH));
  assign w_empty    = (r_count == '0);

  assign exu_stall = ~hrst & (w_full | (w_live_cnt > 2'd1) | ((w_live_cnt == 2'd1) & w_full));

  always_comb begin
    w_win_sel  = '0;
    w_win_addr = '0;
    w_win_data = '0;
    if (w_live[2]) begin
      w_win_sel  = 3'b100;
      w_win_addr = lsu_waddr;
      w_win_data = lsu_wdata;
    end else if (w_live[1]) begin
      w_win_sel  = 3'b010;
      w_win_addr = alu_waddr;
      w_win_data = alu_wdata;
    end else if (w_live[0]) begin
      w_win_sel  = 3'b001;
      w_win_addr = upr_waddr;
      w_win_data = upr_wdata;
    end
  end

  assign w_push = (|w_live) & ~w_full;
  assign rf_wen = ~w_empty & ~hrst;
  assign w_pop  = rf_wen & rf_ready;

  assign rf_waddr = rf_wen ? r_mem_addr[r_rd_ptr] : 5'd0;
  assign rf_wdata = rf_wen ? r_mem_data[r_rd_ptr] : 32'd0;

  always_ff @(posedge hclk) begin
    if (hrst) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
      r_served <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PW'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
      // held requests keep their served mark until the stall drops, so each is pushed once
      if (!exu_stall)  r_served <= '0;
      else if (w_push) r_served <= r_served | w_win_sel;
    end
  end

  always_ff @(posedge hclk) begin
    if (!hrst && w_push) begin
      r_mem_addr[r_wr_ptr] <= w_win_addr;
      r_mem_data[r_wr_ptr] <= w_win_data;
    end
  end

`ifdef EXU_WB_FWD_EN
  logic [PW-1:0] w_idx;

  // walk head to tail so the youngest match overrides older ones
  always_comb begin
    fwd_hit  = 1'b0;
    fwd_data = '0;
    w_idx    = '0;
    for (int k = 0; k < DEPTH; k++) begin
      w_idx = r_rd_ptr + PW'(k);
      if ((CW'(k) < r_count) && (r_mem_addr[w_idx] == fwd_raddr)) begin
        fwd_hit  = 1'b1;
        fwd_data = r_mem_data[w_idx];
      end
    end
    if (hrst || (fwd_raddr == 5'd0)) begin
      fwd_hit  = 1'b0;
      fwd_data = '0;
    end
  end
`else
  logic w_unused_fwd;
  assign w_unused_fwd = ^fwd_raddr;
  assign fwd_hit      = 1'b0;
  assign fwd_data     = '0;
`endif

endmodule

// File: doc/exu_wb_arb.md
# exu_wb_arb

Write-back arbiter and buffer sitting directly downstream of the execute sub-units (upper-immediate, ALU, load/store). It collects their register write requests, serialises them through a small in-order FIFO onto the single register-file write port, and drives `exu_stall` back to the execute sub-units when it cannot absorb requests. An optional forwarding port exposes pending (not yet retired) write data to the operand-read logic.

## Interface
- `DEPTH`, 4: FIFO entries. Power of two, minimum 2.
- `hclk` input 1: clock. All logic is on the rising edge.
- `hrst` input 1: reset, synchronous and active-high.
- `upr_waddr` / `upr_wen` / `upr_wdata` input 5/1/32: write request from the upper-immediate unit.
- `alu_waddr` / `alu_wen` / `alu_wdata` input 5/1/32: write request from the ALU.
- `lsu_waddr` / `lsu_wen` / `lsu_wdata` input 5/1/32: write request from the LSU.
- `exu_stall` output 1: the execute sub-units must hold their request outputs stable. Combinational.
- `rf_waddr` / `rf_wen` / `rf_wdata` output 5/1/32: register-file write port. Driven from the FIFO head.
- `rf_ready` input 1: the register file accepts the write this cycle.
- `fwd_raddr` input 5: forwarding lookup address.
- `fwd_hit` / `fwd_data` output 1/32: the youngest pending FIFO entry matching `fwd_raddr`.

## Operation
- A request is live when `*_wen=1`, `*_waddr!=0`, and its `served` bit is clear. Requests to x0 are discarded silently and never stall.
- Priority among live requests is lsu > alu > upr. The highest-priority live request is the winner.
- Push: when a winner exists and the FIFO is not full, the winner's {waddr, wdata} is written at the tail and its `served` bit is set.
- `exu_stall = full | (live_count > 1) | (live_count == 1 & full)`.
- `served[2:0]`: one bit per source. A source's bit is set when that source is pushed while `exu_stall=1`. All bits clear on any cycle with `exu_stall=0`. This ensures held requests are pushed exactly once.
- Pop: `rf_wen = !empty`. `rf_waddr`/`rf_wdata` equal the head entry. The head retires when `rf_wen & rf_ready`.
- Push and pop may occur in the same cycle; the count is unchanged. A push into a full FIFO never occurs. `full` is based on the registered count only, so there is no `rf_ready`→`exu_stall` combinational path.
- Pointers are `$clog2(DEPTH)` bits and wrap modulo DEPTH. `count` is `$clog2(DEPTH)+1` bits.
- FIFO ordering is strictly in push order. Later pushes to the same register retire later.

## Timing
- Reset (`hrst=1` at an edge): pointers, count, and `served` go to 0. `rf_wen=0`, `rf_waddr=0`, `rf_wdata=0`, `fwd_hit=0`, `fwd_data=0`.
- `exu_stall` is combinational from the request inputs, `served`, and count. While `hrst=1`, `exu_stall=0`.
- Reset mid-operation discards all pending entries. No write is issued in the cycle after reset.
- Latency: a request pushed at edge N appears on `rf_*` after edge N when the FIFO was empty, i.e. in cycle N+1. It retires at the first subsequent edge with `rf_ready=1`.
- Throughput: one push and one retire per cycle.
- Three simultaneous live requests on an empty FIFO with `rf_ready=1` behave as follows:
  - `exu_stall` is high for 2 cycles.
  - Pushes occur in the order lsu, alu, upr on consecutive edges.
  - The first write appears on `rf_*` in the cycle after the first push.

## Configuration
- `EXU_WB_FWD_EN` defined:
  - `fwd_hit=1` when any valid FIFO entry has `waddr==fwd_raddr` and `fwd_raddr!=0`.
  - `fwd_data` is the youngest such entry, i.e. the one nearest the tail.
  - The lookup is combinational over all DEPTH entries.
- `EXU_WB_FWD_EN` undefined: the lookup logic is absent, and `fwd_hit` and `fwd_data` are tied to 0.

## Test plan
- Reset with `upr_wen=1`, `upr_waddr=10` held → all outputs 0 throughout the reset cycles. After reset release, x10 is written exactly once.
- Single upper write: `upr` writes x10 = 0xABCDE000 with `rf_ready=1` → `rf_wen=1`, `rf_waddr=10`, `rf_wdata=0xABCDE000` for exactly one cycle, one cycle after the push. `exu_stall` stays 0.
- Collision: lsu x5=0x11, alu x6=0x22, upr x7=0x33 in the same cycle and held while stalled → `exu_stall`=1 for 2 cycles. The rf writes are x5, x6, x7 on consecutive cycles, with no duplicates.
- Back-pressure: `rf_ready=0`, then DEPTH+1 distinct ALU writes → `exu_stall` rises once count reaches 4. Raising `rf_ready` drains the entries in order and the 5th write is pushed once space frees.
- x0 filter: `alu_wen=1`, `alu_waddr=0` alongside upr x3 → only x3 is written, and `exu_stall=0`.
- Forwarding (with `EXU_WB_FWD_EN`): `rf_ready=0`, push x9=0x1, then x9=0x2, with `fwd_raddr=9` → `fwd_hit=1`, `fwd_data=0x2`. With `fwd_raddr=0` → `fwd_hit=0`.
